// File: rtl/ras_pkg.sv
// ras_pkg: shared constants and helpers for the return-address stack.
//   FULL_REJECT / FULL_CIRCULAR : encodings of the FULL_MODE parameter.
//   ptr_wrap()                  : modulo-DEPTH pointer step. DEPTH need not be
//                                 a power of two, so plain binary wrap is not used.
package ras_pkg;

  localparam int FULL_REJECT   = 0;
  localparam int FULL_CIRCULAR = 1;

  // inc=1 steps forward (DEPTH-1 -> 0), inc=0 steps backward (0 -> DEPTH-1).
  function automatic int ptr_wrap(input int ptr, input logic inc, input int depth);
    if (inc) begin
      return (ptr >= depth - 1) ? 0 : ptr + 1;
    end
    return (ptr == 0) ? depth - 1 : ptr - 1;
  endfunction

endpackage

// File: rtl/ras_storage.sv
// ras_storage: DEPTH x DATA_W register file holding the stacked addresses.
//   clock             : rising-edge clock
//   we, waddr, wdata  : synchronous write port
//   raddr, rdata      : asynchronous (combinational) read port
// Contents are deliberately not reset; the control logic masks reads while empty.
module ras_storage #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// return_addr_stack: parametrised hardware return-address stack for IF.
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset
//   push       : store push_data on top (CALL)
//   pop        : discard top entry (RET)
//   push_data  : return PC to push
//   flush      : empty the stack; overrides push/pop, leaves flags alone
//   clear_err  : clear sticky flags (a same-cycle error still sets them)
//   top_data   : current top entry, combinational, 0 when empty
//   empty/full : count == 0 / count == DEPTH
//   count      : number of valid entries
//   overflow   : sticky, push attempted while full
//   underflow  : sticky, pop attempted while empty
// Outputs depend only on registered state, never on the command inputs.
module return_addr_stack
  import ras_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int FULL_MODE = FULL_REJECT,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              flush,
  input  logic              clear_err,
  output logic [DATA_W-1:0] top_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [PTR_W-1:0]  wp_inc, wp_dec;
  logic              ovf_set, unf_set;
  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [DATA_W-1:0] rdata;

  assign wp_inc = PTR_W'(ptr_wrap(int'(wp_q), 1'b1, DEPTH));
  assign wp_dec = PTR_W'(ptr_wrap(int'(wp_q), 1'b0, DEPTH));

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  // The top entry always sits one slot below the write pointer.
  assign top_data  = empty ? '0 : rdata;

  ras_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_storage (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (push_data),
    .raddr (wp_dec),
    .rdata (rdata)
  );

  always_comb begin
    wp_d    = wp_q;
    count_d = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    we      = 1'b0;
    waddr   = wp_q;

    if (flush) begin
      wp_d    = '0;
      count_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (!full) begin
            we      = 1'b1;
            wp_d    = wp_inc;
            count_d = count_q + CNT_W'(1);
          end else begin
            ovf_set = 1'b1;
            // Circular mode overwrites the oldest slot, which is exactly wp
            // when the stack is full; count saturates at DEPTH.
            if (FULL_MODE == FULL_CIRCULAR) begin
              we   = 1'b1;
              wp_d = wp_inc;
            end
          end
        end
        2'b01: begin
          if (!empty) begin
            wp_d    = wp_dec;
            count_d = count_q - CNT_W'(1);
          end else begin
            unf_set = 1'b1;
          end
        end
        2'b11: begin
          if (!empty) begin
            // Replace top in place: no pointer or count movement, no flags.
            we    = 1'b1;
            waddr = wp_dec;
          end else begin
            // Pop on empty is an error, but the push still lands, rebased at 0.
            unf_set = 1'b1;
            we      = 1'b1;
            waddr   = '0;
            wp_d    = PTR_W'(1);
            count_d = CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    // Set beats clear when both happen in the same cycle.
    ovf_d = ovf_set | (ovf_q & ~clear_err);
    unf_d = unf_set | (unf_q & ~clear_err);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: drives three stack instances with shared commands
// (DEPTH 8 reject, DEPTH 8 circular, DEPTH 5 circular) and compares each
// against a queue-based stack model after every cycle.
module tb_return_addr_stack;

  logic        clock = 1'b0;
  logic        reset;
  logic        push, pop, flush, clear_err;
  logic [31:0] push_data;

  always #5 clock = ~clock;

  logic [31:0] top0, top1, top2;
  logic [3:0]  cnt0, cnt1;
  logic [2:0]  cnt2;
  logic        emp0, emp1, emp2, ful0, ful1, ful2;
  logic        ovf0, ovf1, ovf2, unf0, unf1, unf2;

  return_addr_stack #(.DATA_W(32), .DEPTH(8), .FULL_MODE(0)) u0 (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
    .flush(flush), .clear_err(clear_err), .top_data(top0), .empty(emp0),
    .full(ful0), .count(cnt0), .overflow(ovf0), .underflow(unf0));

  return_addr_stack #(.DATA_W(32), .DEPTH(8), .FULL_MODE(1)) u1 (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
    .flush(flush), .clear_err(clear_err), .top_data(top1), .empty(emp1),
    .full(ful1), .count(cnt1), .overflow(ovf1), .underflow(unf1));

  return_addr_stack #(.DATA_W(32), .DEPTH(5), .FULL_MODE(1)) u2 (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
    .flush(flush), .clear_err(clear_err), .top_data(top2), .empty(emp2),
    .full(ful2), .count(cnt2), .overflow(ovf2), .underflow(unf2));

  logic [31:0] o_top [3];
  logic [31:0] o_cnt [3];
  logic        o_emp [3], o_ful [3], o_ovf [3], o_unf [3];

  assign o_top[0] = top0;        assign o_top[1] = top1;        assign o_top[2] = top2;
  assign o_cnt[0] = 32'(cnt0);   assign o_cnt[1] = 32'(cnt1);   assign o_cnt[2] = 32'(cnt2);
  assign o_emp[0] = emp0;        assign o_emp[1] = emp1;        assign o_emp[2] = emp2;
  assign o_ful[0] = ful0;        assign o_ful[1] = ful1;        assign o_ful[2] = ful2;
  assign o_ovf[0] = ovf0;        assign o_ovf[1] = ovf1;        assign o_ovf[2] = ovf2;
  assign o_unf[0] = unf0;        assign o_unf[1] = unf1;        assign o_unf[2] = unf2;

  // Reference model: one queue per instance, back of queue = top of stack.
  logic [31:0] mq [3][$];
  bit          movf [3];
  bit          munf [3];
  int          mdep [3]  = '{8, 8, 5};
  int          mmode [3] = '{0, 1, 1};

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      mq[m].delete();
      movf[m] = 0;
      munf[m] = 0;
    end
  endtask

  task automatic model_step(input bit pu, input bit po, input logic [31:0] d,
                            input bit fl, input bit cl);
    for (int m = 0; m < 3; m++) begin
      bit so = 0;
      bit su = 0;
      int sz = mq[m].size();
      if (fl) begin
        mq[m].delete();
      end else if (pu && !po) begin
        if (sz < mdep[m]) begin
          mq[m].push_back(d);
        end else begin
          so = 1;
          if (mmode[m] == 1) begin
            void'(mq[m].pop_front());
            mq[m].push_back(d);
          end
        end
      end else if (po && !pu) begin
        if (sz > 0) void'(mq[m].pop_back());
        else        su = 1;
      end else if (po && pu) begin
        if (sz > 0) mq[m][sz-1] = d;
        else begin
          su = 1;
          mq[m].push_back(d);
        end
      end
      movf[m] = so | (movf[m] & !cl);
      munf[m] = su | (munf[m] & !cl);
    end
  endtask

  task automatic check_all(input string tag);
    for (int m = 0; m < 3; m++) begin
      int sz = mq[m].size();
      logic [31:0] et;
      et = (sz > 0) ? mq[m][sz-1] : 32'h0;
      chk($sformatf("%s.m%0d.top", tag, m),   o_top[m], et);
      chk($sformatf("%s.m%0d.count", tag, m), o_cnt[m], 32'(sz));
      chk($sformatf("%s.m%0d.empty", tag, m), 32'(o_emp[m]), 32'(sz == 0));
      chk($sformatf("%s.m%0d.full", tag, m),  32'(o_ful[m]), 32'(sz == mdep[m]));
      chk($sformatf("%s.m%0d.ovf", tag, m),   32'(o_ovf[m]), 32'(movf[m]));
      chk($sformatf("%s.m%0d.unf", tag, m),   32'(o_unf[m]), 32'(munf[m]));
    end
  endtask

  task automatic cyc(input bit pu, input bit po, input logic [31:0] d,
                     input bit fl, input bit cl, input string tag);
    push = pu; pop = po; push_data = d; flush = fl; clear_err = cl;
    @(posedge clock);
    model_step(pu, po, d, fl, cl);
    #1;
    push = 0; pop = 0; flush = 0; clear_err = 0; push_data = '0;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0;
    push = 0; pop = 0; flush = 0; clear_err = 0; push_data = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    chk("reset.top0", top0, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Basic LIFO order.
    cyc(1, 0, 32'h100, 0, 0, "p100");
    cyc(1, 0, 32'h104, 0, 0, "p104");
    cyc(1, 0, 32'h108, 0, 0, "p108");
    chk("lifo.cnt", o_cnt[0], 32'd3);
    chk("lifo.top", o_top[0], 32'h108);
    cyc(0, 1, 0, 0, 0, "pop1");
    chk("lifo.top_after_pop", o_top[0], 32'h104);
    chk("lifo.cnt_after_pop", o_cnt[0], 32'd2);
    cyc(0, 1, 0, 0, 0, "pop2");
    cyc(0, 1, 0, 0, 0, "pop3");
    chk("lifo.empty", 32'(emp0), 32'd1);
    chk("lifo.top_empty", o_top[0], 32'h0);
    chk("lifo.unf", 32'(unf0), 32'd0);

    // Fill to full, then one more push.
    for (int i = 0; i < 8; i++) cyc(1, 0, 32'(i * 4), 0, 0, "fill");
    cyc(1, 0, 32'hFF, 0, 0, "push_full");
    chk("reject.full", 32'(ful0), 32'd1);
    chk("reject.cnt", o_cnt[0], 32'd8);
    chk("reject.ovf", 32'(ovf0), 32'd1);
    chk("reject.top", o_top[0], 32'h1C);
    chk("circ.top", o_top[1], 32'hFF);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("reject.last_read", o_top[0], 32'h0);
      cyc(0, 1, 0, 0, 0, "drain");
    end

    // Circular overwrite.
    cyc(0, 0, 0, 1, 1, "flush_clr");
    for (int i = 0; i < 10; i++) cyc(1, 0, 32'(i * 4), 0, 0, "circ_fill");
    chk("circ.cnt", o_cnt[1], 32'd8);
    chk("circ.ovf", 32'(ovf1), 32'd1);
    chk("circ.top_fill", o_top[1], 32'h24);
    for (int i = 0; i < 8; i++) begin
      chk("circ.pop_val", o_top[1], 32'(32'h24 - i * 4));
      cyc(0, 1, 0, 0, 0, "circ_drain");
    end
    chk("circ.empty", 32'(emp1), 32'd1);

    // Same-cycle push+pop.
    cyc(0, 0, 0, 1, 1, "flush_clr");
    cyc(1, 0, 32'hA0, 0, 0, "pA0");
    cyc(1, 1, 32'hB0, 0, 0, "replB0");
    chk("repl.cnt", o_cnt[0], 32'd1);
    chk("repl.top", o_top[0], 32'hB0);
    cyc(0, 0, 0, 1, 0, "flush");
    cyc(1, 1, 32'hC0, 0, 0, "replC0_empty");
    chk("repl_empty.unf", 32'(unf0), 32'd1);
    chk("repl_empty.cnt", o_cnt[0], 32'd1);
    chk("repl_empty.top", o_top[0], 32'hC0);

    // Sticky flag clearing and set-beats-clear.
    cyc(0, 0, 0, 1, 1, "flush_clr");
    cyc(0, 1, 0, 0, 0, "pop_empty");
    chk("unf.set", 32'(unf0), 32'd1);
    cyc(0, 0, 0, 0, 1, "clr");
    chk("unf.cleared", 32'(unf0), 32'd0);
    cyc(0, 1, 0, 0, 1, "clr_and_pop");
    chk("unf.set_wins", 32'(unf0), 32'd1);

    // Flush priority; flags survive flush.
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h200 + 32'(i), 0, 0, "pre_flush");
    cyc(1, 0, 32'hDD, 1, 0, "flush_push");
    chk("flush.cnt", o_cnt[0], 32'd0);
    chk("flush.empty", 32'(emp0), 32'd1);
    chk("flush.unf_kept", 32'(unf0), 32'd1);

    // Asynchronous reset mid-cycle with count=5.
    for (int i = 0; i < 5; i++) cyc(1, 0, 32'h300 + 32'(i), 0, 0, "pre_rst");
    chk("pre_rst.cnt", o_cnt[0], 32'd5);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.cnt", o_cnt[0], 32'd0);
    @(negedge clock);
    reset = 1'b1;
    cyc(1, 0, 32'h400, 0, 0, "first_after_rst");
    chk("after_rst.cnt", o_cnt[0], 32'd1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      bit pu, po, fl, cl;
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 3);
      cl = ($urandom_range(0, 99) < 6);
      cyc(pu, po, $urandom, fl, cl, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Parametrised hardware return-address stack for the IF stage.
- The control unit pushes the return PC on CALL and pops it on RET.
- Replaces the fixed 8x32 stack with configurable width and depth, and adds:
  - zero-latency top-of-stack read
  - same-cycle push+pop (replace top)
  - selectable full-stack policy
  - flush
  - separate sticky overflow and underflow flags with clear
  - occupancy reporting

Parameters:
- DATA_W, 32, width of each stored address.
- DEPTH, 8, number of entries; integer >= 2, need not be a power of two.
- FULL_MODE, 0, policy on push when full: 0 = reject the push; 1 = circular, overwriting the oldest entry.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- push, input, 1, store push_data on top (CALL).
- pop, input, 1, discard top entry (RET).
- push_data, input, DATA_W, address to push (return PC).
- flush, input, 1, empty the stack (pipeline flush or context switch).
- clear_err, input, 1, clear the sticky error flags.
- top_data, output, DATA_W, current top entry, combinational; 0 when empty.
- empty, output, 1, count == 0.
- full, output, 1, count == DEPTH.
- count, output, CNT_W, number of valid entries.
- overflow, output, 1, sticky: push attempted while full.
- underflow, output, 1, sticky: pop attempted while empty.

Behaviour:
- Reset is asynchronous and active-low.
  - On reset: count=0, write pointer=0, overflow=0, underflow=0.
  - Storage array is not reset, but top_data reads 0 because empty=1.
- Reset asserted mid-operation discards the in-flight command; the first command is accepted on the first rising edge after deassertion.
- All other state updates on the rising edge of clock.
- Read latency is 0: top_data = mem[(wp-1) mod DEPTH] when count>0, else 0.
  - A consumer samples top_data in the same cycle it asserts pop.
- Pointer arithmetic: wp wraps DEPTH-1 -> 0 and 0 -> DEPTH-1 (decrement). It never uses plain binary overflow unless DEPTH is a power of two.
- Command priority per cycle: flush > push/pop.
  - flush=1: count <- 0, wp <- 0.
  - push and pop in a flush cycle are ignored.
  - Flags are unchanged by flush.
- push=1, pop=0:
  - Not full: mem[wp] <- push_data, wp++, count++.
  - Full, FULL_MODE=0: no write, state unchanged, overflow <- 1.
  - Full, FULL_MODE=1: mem[wp] <- push_data, wp++, count stays DEPTH (oldest entry lost), overflow <- 1.
- push=0, pop=1:
  - Not empty: wp--, count--.
  - Empty: state unchanged, underflow <- 1.
- push=1, pop=1:
  - Not empty: replace top, i.e. mem[wp-1] <- push_data; wp and count unchanged; no flag set, even when full.
  - Empty: underflow <- 1, then the push is performed (mem[0] <- push_data, wp=1, count=1).
- Flag clearing:
  - clear_err=1 clears both flags.
  - If an error condition occurs in the same cycle, the set wins (flag = 1).
- full, empty and top_data derive from registered count/wp only. There is no combinational path from push/pop/push_data to any output.

Decomposition:
- Package ras_pkg holds:
  - FULL_REJECT=0 and FULL_CIRCULAR=1 constants
  - a function for wrapped pointer increment/decrement, taking DEPTH as an argument
- One natural sub-module, ras_storage:
  - DEPTH x DATA_W register file
  - one synchronous write port and one asynchronous read port
  - no reset
- Pointer/count/flag control stays in return_addr_stack.

Test Plan (DATA_W=32, DEPTH=8 unless stated):
- Reset, then push 0x100,0x104,0x108 on consecutive cycles -> count=3, top_data=0x108; pop -> top_data=0x104, count=2; pop twice -> empty=1, top_data=0, underflow=0.
- FULL_MODE=0: push 0x0..0x1C (8 pushes), then push 0xFF -> full=1, count=8, overflow=1, top_data=0x1C; pop eight times -> last value read 0x0.
- FULL_MODE=1: push 0x0..0x24 (10 pushes) -> count=8, overflow=1, top_data=0x24; eight pops yield 0x24 down to 0x8, then empty=1.
- Push 0xA0, then same-cycle push 0xB0 + pop -> count=1, top_data=0xB0; on an empty stack, same-cycle push 0xC0 + pop -> underflow=1, count=1, top_data=0xC0.
- Pop on empty -> underflow=1; next cycle clear_err alone -> underflow=0; clear_err together with a pop on empty -> underflow stays 1.
- Push 3 entries, assert flush together with push 0xDD -> count=0, empty=1, flags unchanged; assert reset asynchronously mid-cycle with count=5 -> count=0 immediately, before the next edge.
